// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: opcodes, function codes, ALU op encoding,
// the decode-to-execute packet and immediate/ALU-op helpers.
package rv32_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        rd_we;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] imm;
        alu_op_t     alu_op;
        logic        use_imm;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } dec2ex_t;

    // Sign-extended immediate for the format implied by the opcode
    function automatic logic [31:0] imm_gen(input logic [31:0] inst);
        case (inst[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_gen = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:  imm_gen = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH: imm_gen = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm_gen = {inst[31:12], 12'b0};
            OPC_JAL:    imm_gen = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:    imm_gen = '0;
        endcase
    endfunction

    // Arithmetic ALU op from funct3; alt selects SUB/SRA variants
    function automatic alu_op_t arith_op(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD:  arith_op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  arith_op = ALU_SLL;
            F3_SLT:  arith_op = ALU_SLT;
            F3_SLTU: arith_op = ALU_SLTU;
            F3_XOR:  arith_op = ALU_XOR;
            F3_SR:   arith_op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_regfile.sv
// Architectural register file: two asynchronous reads, one synchronous write.
// x0 and addresses beyond NREG read as zero and are never written.
module rv32_regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];

    // Write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0 && 32'(waddr) < NREG)
            regs[waddr[AW-1:0]] <= wdata;
    end

    assign rdata1 = (raddr1 == 5'd0 || 32'(raddr1) >= NREG) ? '0 : regs[raddr1[AW-1:0]];
    assign rdata2 = (raddr2 == 5'd0 || 32'(raddr2) >= NREG) ? '0 : regs[raddr2[AW-1:0]];

endmodule

// File: rtl/inst_dec_rv32.sv
// RV32I/RV32E decode stage: owns the fetch PC, holds one IF packet, decodes it
// into an EX packet with WB bypass and a single-bubble load-use interlock.
module inst_dec_rv32
    import rv32_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter bit              FWD_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] if_pc_o,
    input  logic            if_valid_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_inst_i,
    output logic            if_ready_o,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output dec2ex_t         ex_pkt_o,
    input  logic            redir_i,
    input  logic [XLEN-1:0] redir_pc_i,
    input  logic            wb_we_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i
);
    logic            stage_valid;
    logic [XLEN-1:0] stage_pc;
    logic [31:0]     stage_inst;
    logic            trk_valid;
    logic [4:0]      trk_rd;
    logic            hazard, if_fire, ex_fire;
    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] rf_rdata1, rf_rdata2, rs1_val, rs2_val;
    logic            uses_rs1, uses_rs2, uses_rd, illegal, rd_we;
    dec2ex_t         pkt;

    assign opcode = stage_inst[6:0];
    assign rd     = stage_inst[11:7];
    assign funct3 = stage_inst[14:12];
    assign rs1    = stage_inst[19:15];
    assign rs2    = stage_inst[24:20];
    assign funct7 = stage_inst[31:25];

    rv32_regfile #(.NREG(NREG), .XLEN(XLEN)) u_regfile (
        .clk    (clk),
        .we     (wb_we_i),
        .waddr  (wb_rd_i),
        .wdata  (wb_data_i),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Operand read with optional bypass of the value being written back this cycle
    always_comb begin
        rs1_val = rf_rdata1;
        rs2_val = rf_rdata2;
        if (FWD_EN && wb_we_i && wb_rd_i == rs1 && rs1 != 5'd0) rs1_val = wb_data_i;
        if (FWD_EN && wb_we_i && wb_rd_i == rs2 && rs2 != 5'd0) rs2_val = wb_data_i;
    end

    // Instruction decode into the EX packet
    always_comb begin
        pkt      = '0;
        illegal  = 1'b0;
        rd_we    = 1'b0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        uses_rd  = 1'b0;
        pkt.pc     = stage_pc;
        pkt.inst   = stage_inst;
        pkt.rd     = rd;
        pkt.imm    = imm_gen(stage_inst);
        pkt.alu_op = ALU_ADD;
        pkt.src1   = rs1_val;
        case (opcode)
            OPC_OP: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1; rd_we = 1'b1;
                pkt.alu_op = arith_op(funct3, funct7[5]);
                if (funct7 == F7_ALT)       illegal = !(funct3 == F3_ADD || funct3 == F3_SR);
                else if (funct7 != F7_BASE) illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1; rd_we = 1'b1; pkt.use_imm = 1'b1;
                pkt.alu_op = arith_op(funct3, (funct3 == F3_SR) && funct7[5]);
                if (funct3 == F3_SLL)     illegal = (funct7 != F7_BASE);
                else if (funct3 == F3_SR) illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
            end
            OPC_LOAD: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1; rd_we = 1'b1;
                pkt.use_imm = 1'b1; pkt.is_load = 1'b1;
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                pkt.use_imm = 1'b1; pkt.is_store = 1'b1;
                illegal = (funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; pkt.is_branch = 1'b1;
                case (funct3)
                    3'b000:  pkt.alu_op = ALU_BEQ;
                    3'b001:  pkt.alu_op = ALU_BNE;
                    3'b100:  pkt.alu_op = ALU_BLT;
                    3'b101:  pkt.alu_op = ALU_BGE;
                    3'b110:  pkt.alu_op = ALU_BLTU;
                    3'b111:  pkt.alu_op = ALU_BGEU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                uses_rd = 1'b1; rd_we = 1'b1; pkt.is_jump = 1'b1; pkt.src1 = stage_pc;
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1; uses_rd = 1'b1; rd_we = 1'b1; pkt.is_jump = 1'b1;
                pkt.src1 = stage_pc;
                illegal = (funct3 != 3'b000);
            end
            OPC_LUI: begin
                uses_rd = 1'b1; rd_we = 1'b1; pkt.use_imm = 1'b1; pkt.src1 = '0;
            end
            OPC_AUIPC: begin
                uses_rd = 1'b1; rd_we = 1'b1; pkt.use_imm = 1'b1; pkt.src1 = stage_pc;
            end
            default: illegal = 1'b1;
        endcase
        if (NREG < 32 && ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (uses_rd && rd[4])))
            illegal = 1'b1;
        pkt.src2 = pkt.use_imm ? pkt.imm : rs2_val;
        if (pkt.is_jump) pkt.src2 = 32'd4;
        pkt.illegal = illegal;
        pkt.rd_we   = rd_we && (rd != 5'd0) && !illegal;
    end

    assign hazard     = trk_valid && stage_valid &&
                        ((rs1 == trk_rd) || (uses_rs2 && rs2 == trk_rd));
    assign if_ready_o = !stage_valid || (ex_ready_i && !hazard);
    assign ex_valid_o = stage_valid && !hazard && !redir_i;
    assign if_fire    = if_valid_i && if_ready_o;
    assign ex_fire    = ex_valid_o && ex_ready_i;
    assign ex_pkt_o   = stage_valid ? pkt : '0;

    // Stage register: redirect squashes, otherwise load from IF or drain to EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= 1'b0;
            stage_pc    <= '0;
            stage_inst  <= '0;
        end else if (redir_i) begin
            stage_valid <= 1'b0;
        end else if (if_fire) begin
            stage_valid <= 1'b1;
            stage_pc    <= if_pc_i;
            stage_inst  <= if_inst_i;
        end else if (ex_fire) begin
            stage_valid <= 1'b0;
        end
    end

    // Fetch PC: redirect beats sequential advance; low two bits kept clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          if_pc_o <= RESET_PC & ~XLEN'(3);
        else if (redir_i) if_pc_o <= redir_pc_i & ~XLEN'(3);
        else if (if_fire) if_pc_o <= if_pc_o + XLEN'(4);
    end

    // Load-use tracker: remembers a load's destination for exactly one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trk_valid <= 1'b0;
            trk_rd    <= '0;
        end else begin
            trk_valid <= ex_fire && pkt.is_load && pkt.rd_we;
            if (ex_fire) trk_rd <= pkt.rd;
        end
    end

endmodule

// File: doc/inst_dec_rv32.md
Name: inst_dec_rv32

Overview:
- Parametrised successor decode stage. Decodes all RV32I/RV32E base formats (R/I/S/B/U/J) into an EX packet.
- Owns the fetch PC register with branch/jump redirect from EX.
- Uses a valid/ready handshake on both sides instead of a global stall.
- Adds writeback forwarding and a load-use interlock. Sits between the IF and EX stages.

Parameters:
- XLEN, 32, datapath width; only 32 is legal. Kept for the shared package.
- NREG, 32, architectural register count. 32 selects RV32I, 16 selects RV32E.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FWD_EN, 1, 1 enables WB-to-decode bypass. 0 makes same-cycle RAW read the old register file value.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- if_pc_o  out  XLEN  fetch address
- if_valid_i  in  1  IF packet valid
- if_pc_i  in  XLEN  PC of fetched instruction
- if_inst_i  in  32  fetched instruction
- if_ready_o  out  1  decode accepts packet this cycle
- ex_valid_o  out  1  decoded packet valid
- ex_ready_i  in  1  EX accepts packet
- ex_pkt_o  out  dec2ex_t  {pc, inst, rd, rd_we, src1, src2, imm, alu_op, use_imm, is_load, is_store, is_branch, is_jump, illegal}
- redir_i  in  1  EX branch/jump taken
- redir_pc_i  in  XLEN  redirect target
- wb_we_i  in  1  writeback enable
- wb_rd_i  in  5  writeback register
- wb_data_i  in  XLEN  writeback data

Behaviour:
- Reset (async assert, sync release):
  - if_pc_o=RESET_PC; stage register valid=0; ex_valid_o=0; ex_pkt_o=0; load-use tracker cleared; register file contents not reset.
- Stage register:
  - Loads the IF packet when if_valid_i & if_ready_o.
  - Condition: if_ready_o = ~stage_valid | (ex_ready_i & ~hazard).
- EX output handshake:
  - ex_valid_o = stage_valid & ~hazard & ~redir_i.
  - Packet leaves on ex_valid_o & ex_ready_i.
  - While ex_valid_o=1 and ex_ready_i=0, ex_pkt_o is held stable.
- PC:
  - Priority: redir_i, then advance, then hold.
  - redir_i: if_pc_o <= redir_pc_i, and stage_valid is cleared (squash) in the same edge.
  - Otherwise, if_pc_o <= if_pc_o + 4 when if_valid_i & if_ready_o; else hold.
  - Bit [1:0] of the PC is always 0; redir_pc_i[1:0] is forced to 0.
- Decode:
  - rd/rs1/rs2 come from inst fields [11:7], [19:15], [24:20].
  - Immediates are sign-extended per format. U format = {inst[31:12], 12'b0}. B and J place bit 0 = 0.
  - src2 = imm when use_imm=1, else rs2 value.
  - OP, OP-IMM: funct3/funct7 select alu_op. funct7[5] matters only for ADD/SUB (OP only) and SRL/SRA.
  - LOAD/STORE: alu_op=ADD. JAL/JALR: alu_op=ADD with src1=pc, src2=4. LUI: src1=0. AUIPC: src1=pc.
  - BRANCH: alu_op from funct3 (BEQ..BGEU). rd_we=0.
  - rd_we=0 when rd==0.
  - illegal=1, rd_we=0, ex_valid_o still 1 for:
    - unknown opcode, or reserved funct3/funct7 encodings;
    - with NREG=16, any register field >=16.
- Register read:
  - x0 always reads 0.
  - When FWD_EN=1, wb_we_i & wb_rd_i==rs & rs!=0 returns wb_data_i in the same cycle.
  - RF write happens at the clock edge; wb_we_i with wb_rd_i==0 is ignored.
- Load-use hazard:
  - Tracker records {valid, rd} when an is_load packet with rd_we=1 is accepted by EX. It clears the following cycle unless refreshed.
  - hazard = tracker.valid & (rs1==tracker.rd | rs2==tracker.rd (rs2 only if the format uses it)) & stage_valid.
  - Result: exactly one bubble.
- Simultaneous events:
  - redir_i overrides hazard and an accepted IF packet; the packet arriving that cycle is dropped.
  - A WB write and a read of the same register in the same cycle forward as described under Register read.

Decomposition:
- Package rv32_pkg holds:
  - opcode/funct3/funct7 localparams;
  - alu_op_t enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU;
  - the dec2ex_t struct;
  - an imm_gen function.
- One sub-module: rv32_regfile(NREG) with 2 asynchronous read ports and 1 synchronous write port.

Test Plan:
- Reset mid-run, then release -> if_pc_o=0, ex_valid_o=0; the first accepted inst at pc 0 appears with ex_valid_o=1 one cycle later.
- ADDI x1,x0,-5 (32'hFFB00093) -> rd=1, rd_we=1, imm=32'hFFFF_FFFB, alu_op=ADD, use_imm=1. SUB x3,x1,x2 -> alu_op=SUB; SRAI x4,x1,3 -> SRA, imm[4:0]=3.
- Forwarding: wb_we_i=1, wb_rd_i=5, wb_data_i=32'hDEAD_BEEF, same cycle as decoding ADD x6,x5,x0 -> src1=32'hDEAD_BEEF. wb_rd_i=0 -> src1 from x0 = 0.
- LW x7,0(x2) then ADD x8,x7,x7 -> one cycle with ex_valid_o=0 and if_ready_o=0, then ADD issues. An independent inst after LW issues with no bubble.
- ex_ready_i=0 for 3 cycles with a valid packet -> ex_pkt_o stable, if_pc_o constant, no packet lost.
- redir_i=1, redir_pc_i=32'h100 while the stage holds an inst -> next cycle if_pc_o=32'h100, squashed inst never reaches EX. Opcode 7'b1111111 -> illegal=1, rd_we=0.
